// File: rtl/rf_mp_sb.sv
// rf_mp_sb: parametrised multi-port register file with a pending-write
// scoreboard used by the IDU for RAW hazard stalls.
//
// Ports:
//   clk, rst  - clock (rising edge), synchronous active-high reset
//   rd_addr   - NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   - NUM_RD packed read data (combinational)
//   rd_busy   - per read port: addressed register has an outstanding producer
//   wr_vld    - per write port enable
//   wr_addr   - NUM_WR packed write addresses
//   wr_data   - NUM_WR packed write data
//   iss_vld   - an instruction with a destination is issued this cycle
//   iss_addr  - destination register of the issued instruction
//   pend_cnt  - registered number of registers currently pending

// One read port: zero-latency mux over the array with optional same-cycle
// forwarding of write data.
module rf_mp_sb_rd #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
  input  logic [DEPTH-1:0]              pend,
  input  logic [DEPTH-1:0]              wen,
  input  logic [DEPTH-1:0][DATA_W-1:0]  wdat,
  output logic [DATA_W-1:0]             data,
  output logic                          busy
);
  // Out-of-range addresses match no j and fall through to the 0/0 default.
  always_comb begin
    data = '0;
    busy = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (addr == ADDR_W'(j) && !(ZERO_REG != 0 && j == 0)) begin
        if (BYPASS != 0 && wen[j]) begin
          data = wdat[j];
          busy = 1'b0;
        end else begin
          data = regs[j];
          busy = pend[j];
        end
      end
    end
  end
endmodule

module rf_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_vld,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_vld,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt
);
  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0][DATA_W-1:0] wdat;
  logic [DEPTH-1:0]             pend, pend_nxt, wen, iss_hit;
  logic [ADDR_W:0]              cnt_nxt;

  // Per-register write decode. Ports are scanned in ascending order so the
  // highest-index matching port wins. Register 0 (when hardwired) never
  // matches; writes coinciding with reset are dropped, including forwarding.
  always_comb begin
    wen     = '0;
    wdat    = '0;
    iss_hit = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (!(ZERO_REG != 0 && j == 0)) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_vld[i] && wr_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(j)) begin
            wen[j]  = 1'b1;
            wdat[j] = wr_data[i*DATA_W +: DATA_W];
          end
        end
        iss_hit[j] = iss_vld && (iss_addr == ADDR_W'(j));
      end
    end
    if (rst) wen = '0;
  end

  // A new producer issued in the same cycle as a writeback supersedes it,
  // so the issue term dominates the clear.
  always_comb begin
    pend_nxt = iss_hit | (pend & ~wen);
    cnt_nxt  = '0;
    for (int j = 0; j < DEPTH; j++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[j]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs     <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++)
        if (wen[j]) regs[j] <= wdat[j];
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_mp_sb_rd #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .addr (rd_addr[k*ADDR_W +: ADDR_W]),
      .regs (regs),
      .pend (pend),
      .wen  (wen),
      .wdat (wdat),
      .data (rd_data[k*DATA_W +: DATA_W]),
      .busy (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_rf_mp_sb.sv
// Scoreboard bench for rf_mp_sb. Two instances share stimulus:
//   dut0: defaults (DEPTH=32, BYPASS=1)
//   dut1: DEPTH=24, BYPASS=0 (exercises out-of-range and no-forward paths)
module tb_rf_mp_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NW-1:0]     wr_vld = '0;
  logic [NW*AW-1:0]  wr_addr = '0;
  logic [NW*DW-1:0]  wr_data = '0;
  logic              iss_vld = 1'b0;
  logic [AW-1:0]     iss_addr = '0;
  logic [NR*DW-1:0]  rd_data0, rd_data1;
  logic [NR-1:0]     rd_busy0, rd_busy1;
  logic [AW:0]       pend_cnt0, pend_cnt1;

  always #5 clk = ~clk;

  rf_mp_sb dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_vld(iss_vld), .iss_addr(iss_addr), .pend_cnt(pend_cnt0));

  rf_mp_sb #(.DEPTH(24), .BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_vld(iss_vld), .iss_addr(iss_addr), .pend_cnt(pend_cnt1));

  typedef struct packed {
    logic [1:0][NR*DW-1:0] data;
    logic [1:0][NR-1:0]    busy;
    logic [1:0][AW:0]      cnt;
    int                    cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: architectural state per instance.
  logic [DW-1:0] mem [2][32];
  bit            pnd [2][32];

  function automatic int dep(input int m);
    return (m == 0) ? 32 : 24;
  endfunction

  function automatic bit legal(input int m, input int a);
    return (a != 0) && (a < dep(m));
  endfunction

  task automatic step(input bit r, input logic [1:0] wv,
                      input int wa0, input logic [DW-1:0] wd0,
                      input int wa1, input logic [DW-1:0] wd1,
                      input bit iv, input int ia, input int ra0, input int ra1);
    exp_t e;
    int wa[2], ra[2];
    logic [DW-1:0] wd[2];
    wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
    ra[0] = ra0; ra[1] = ra1;
    @(posedge clk); #1;
    rst      = r;
    wr_vld   = wv;
    wr_addr  = {AW'(wa1), AW'(wa0)};
    wr_data  = {wd1, wd0};
    iss_vld  = iv;
    iss_addr = AW'(ia);
    rd_addr  = {AW'(ra1), AW'(ra0)};
    cyc++;
    e = '0;
    e.cyc = cyc;
    // Expected combinational view, before this cycle's edge.
    for (int m = 0; m < 2; m++) begin
      int n = 0;
      for (int k = 0; k < NR; k++) begin
        logic [DW-1:0] d;
        bit b;
        d = '0; b = 0;
        if (legal(m, ra[k])) begin
          d = mem[m][ra[k]];
          b = pnd[m][ra[k]];
          if (m == 0 && !r)
            for (int i = 0; i < NW; i++)
              if (wv[i] && wa[i] == ra[k]) begin d = wd[i]; b = 0; end
        end
        e.data[m][k*DW +: DW] = d;
        e.busy[m][k] = b;
      end
      for (int j = 0; j < 32; j++) n += pnd[m][j];
      e.cnt[m] = (AW+1)'(n);
    end
    q.push_back(e);
    // Advance model state to after the edge.
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        for (int j = 0; j < 32; j++) begin mem[m][j] = '0; pnd[m][j] = 0; end
      end else begin
        for (int i = 0; i < NW; i++)
          if (wv[i] && legal(m, wa[i])) begin mem[m][wa[i]] = wd[i]; pnd[m][wa[i]] = 0; end
        if (iv && legal(m, ia)) pnd[m][ia] = 1;
      end
    end
  endtask

  task automatic rd(input int a0, input int a1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int m = 0; m < 2; m++) begin
          logic [NR*DW-1:0] ad;
          logic [NR-1:0]    ab;
          logic [AW:0]      ac;
          ad = m ? rd_data1 : rd_data0;
          ab = m ? rd_busy1 : rd_busy0;
          ac = m ? pend_cnt1 : pend_cnt0;
          tests += 3;
          if (ad !== e.data[m]) begin
            fails++;
            $display("FAIL rd_data dut%0d cyc%0d: got %h want %h", m, e.cyc, ad, e.data[m]);
          end
          if (ab !== e.busy[m]) begin
            fails++;
            $display("FAIL rd_busy dut%0d cyc%0d: got %b want %b", m, e.cyc, ab, e.busy[m]);
          end
          if (ac !== e.cnt[m]) begin
            fails++;
            $display("FAIL pend_cnt dut%0d cyc%0d: got %0d want %0d", m, e.cyc, ac, e.cnt[m]);
          end
        end
      end
    end
  end

  initial begin
    for (int m = 0; m < 2; m++)
      for (int j = 0; j < 32; j++) begin mem[m][j] = '0; pnd[m][j] = 0; end

    // Reset with concurrent writes and issue: all discarded.
    step(1, 2'b11, 5, 32'h1111_1111, 6, 32'h2222_2222, 1, 9, 5, 6);
    step(1, 2'b11, 5, 32'h1111_1111, 6, 32'h2222_2222, 1, 9, 9, 0);
    rd(5, 6);
    rd(9, 31);

    // Basic write/read; register 0 stays zero.
    step(0, 2'b01, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 5, 5);
    rd(5, 5);
    step(0, 2'b01, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 5);
    rd(0, 0);

    // Same-cycle forwarding (dut0) vs. none (dut1).
    step(0, 2'b10, 0, 0, 7, 32'h55, 0, 0, 7, 7);
    rd(7, 7);

    // Port conflict: higher port wins.
    step(0, 2'b11, 3, 32'h11, 3, 32'h22, 0, 0, 3, 0);
    rd(3, 3);

    // Scoreboard.
    step(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 9);
    rd(9, 9);
    step(0, 2'b01, 9, 32'hA5, 0, 0, 1, 9, 9, 9);
    rd(9, 9);
    step(0, 2'b01, 9, 32'hB6, 0, 0, 0, 0, 9, 9);
    rd(9, 9);

    // Out-of-range for dut1 (DEPTH=24).
    step(0, 2'b11, 26, 32'hCAFE, 23, 32'hBEEF, 1, 28, 26, 23);
    rd(26, 23);
    step(0, 2'b00, 0, 0, 0, 0, 1, 0, 28, 0);
    rd(0, 28);

    // Mid-operation reset.
    step(0, 2'b00, 0, 0, 0, 0, 1, 1, 1, 2);
    step(0, 2'b00, 0, 0, 0, 0, 1, 2, 1, 2);
    step(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 1);
    rd(1, 3);
    step(1, 2'b01, 1, 32'hFF, 0, 0, 0, 0, 1, 2);
    rd(1, 3);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0), 2'($urandom),
           $urandom_range(0, 31), $urandom, $urandom_range(0, 31), $urandom,
           ($urandom_range(0, 2) != 0), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 4 && q.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_mp_sb.md
Name: rf_mp_sb

Overview:
- Parametrised multi-port integer register file with an integrated pending-write scoreboard.
- Successor to the single-write, two-read register file. Adds configurable width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass and per-register busy tracking, which the IDU uses for RAW hazard stalls.
- Sits between IDU (read and issue side) and LSU/ALU writeback.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of architectural registers (2..2^ADDR_W).
- ADDR_W, 5, register address width.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero.
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data per port.
- rd_busy  out  NUM_RD  1 = the addressed register has an outstanding producer.
- wr_vld  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- iss_vld  in  1  an instruction with a destination register is issued this cycle.
- iss_addr  in  ADDR_W  destination register of the issued instruction.
- pend_cnt  out  ADDR_W+1  number of registers currently marked pending (registered).

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - While rst=1 at a clk edge: all registers clear to 0, all pending bits clear, pend_cnt becomes 0.
  - A write or issue in the same cycle as rst is discarded.
  - rd_data and rd_busy are combinational, so after reset they read 0.
- Storage:
  - DEPTH x DATA_W flops, updated on the clk edge.
  - Register j loads when some port i has wr_vld[i]=1 and wr_addr_i==j.
  - Multiple ports writing the same address in one cycle: the highest-index port wins. No error is flagged.
- Register 0 (ZERO_REG=1):
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0 with busy=0.
  - iss_vld with iss_addr=0 sets nothing.
- Out-of-range addresses (addr >= DEPTH):
  - Writes are ignored.
  - Reads return 0 with busy=0.
  - Issues are ignored.
- Read path, zero latency:
  - rd_data_k = stored[rd_addr_k].
  - When BYPASS=1 and a valid write targets rd_addr_k this cycle, rd_data_k = the winning wr_data instead (same priority rule as storage).
  - Bypass never applies to register 0.
- Scoreboard: one pending bit per register.
  - Set next cycle when iss_vld=1 and iss_addr is in range and nonzero.
  - Cleared next cycle when a valid write targets that register.
  - Issue and write to the same register in the same cycle: pending ends SET, because the new producer supersedes.
  - Issue to a register that is already pending: it stays pending. There is no counting; one outstanding producer per register is the IDU's responsibility.
- rd_busy_k:
  - Equals pending[rd_addr_k].
  - When BYPASS=1 and a valid write to rd_addr_k occurs this cycle, rd_busy_k = 0. The same-cycle iss_vld does not affect rd_busy until the next cycle.
- pend_cnt:
  - Registered popcount of the pending bits, updated the same edge as the pending bits.
  - Maximum value is DEPTH-ZERO_REG; no wrap.

Test Plan:
- Reset then read all: assert rst for 2 cycles with wr_vld=2'b11 and iss_vld=1 → every rd_data=0, rd_busy=0, pend_cnt=0.
- Write 0xDEADBEEF to r5 via port0, then read r5 on both ports → rd_data=0xDEADBEEF on both, busy=0. Repeat writing r0=0x1234 → read r0 returns 0.
- Bypass: write r7=0x55 via port1 and read r7 in the same cycle → rd_data=0x55 when BYPASS=1. With BYPASS=0 → old value 0, then 0x55 the next cycle.
- Port conflict: port0 writes r3=0x11 and port1 writes r3=0x22 in the same cycle → next cycle r3 reads 0x22.
- Scoreboard:
  - Issue r9 → next cycle rd_busy=1 and pend_cnt=1.
  - Write r9=0xA5 with iss_vld to r9 in the same cycle → r9=0xA5 with busy still 1.
  - Write r9=0xB6 with no issue → busy=0 and pend_cnt=0.
- Mid-operation reset: issue r1, r2 and r3 over 3 cycles (pend_cnt=3), then rst for 1 cycle with a concurrent write r1=0xFF → pend_cnt=0, r1 reads 0, all busy=0.
